// File: rtl/raster_fb_write_scheduler_pkg.sv
// Shared definitions for the framebuffer write scheduler.
//   - FSM state encoding
//   - default framebuffer geometry
//   - RGB24 packing and the clip / linear-address helpers
package raster_fb_write_scheduler_pkg;

    localparam int FB_WIDTH_DEF  = 320;
    localparam int FB_HEIGHT_DEF = 240;
    localparam int RGB_W         = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PIXEL = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } fb_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic rgb_t rgb_pack(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
        rgb_t c;
        c.r = r;
        c.g = g;
        c.b = b;
        return c;
    endfunction

    // Coordinates are signed; anything negative or past the edge is off-screen.
    function automatic logic pix_in_bounds(input logic signed [15:0] x,
                                           input logic signed [15:0] y,
                                           input int w, input int h);
        return (int'(x) >= 0) && (int'(x) < w) && (int'(y) >= 0) && (int'(y) < h);
    endfunction

    // Row-major word address. Only meaningful for in-bounds coordinates.
    function automatic int fb_addr(input logic signed [15:0] x,
                                   input logic signed [15:0] y, input int w);
        return int'(y) * w + int'(x);
    endfunction

endpackage

// File: rtl/raster_fb_write_scheduler_pixel_fifo.sv
// Synchronous fall-through FIFO for clipped, address-resolved pixel writes.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_wdata  write side; a push on a full FIFO is only taken when a
//                    pop happens in the same cycle
//   i_pop, o_rdata   read side; o_rdata shows the head entry while not empty
//   o_count          current occupancy
//   o_full, o_empty  occupancy flags
module raster_fb_write_scheduler_pixel_fifo #(
    parameter  int DEPTH = 8,
    parameter  int DW    = 41,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = mem_q[rd_ptr_q];

    assign pop_ok  = i_pop & ~o_empty;
    assign push_ok = i_push & (~o_full | pop_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/raster_fb_write_scheduler.sv
// Framebuffer write scheduler behind the texture stage.
// Clips off-screen pixels, queues the rest (EX3 cannot be back-pressured),
// throttles the raster front-end and shares the single framebuffer port with
// a full-screen clear engine while keeping pixel/clear order.
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_write_pixel, i_x, i_y,
//   i_r, i_g, i_b                pixel stream from EX3 (signed coordinates)
//   o_stall                      front-end throttle (registered)
//   i_clear_req, i_clear_rgb     single-cycle clear request and colour
//   o_clear_busy, o_clear_done   clear in progress / last clear write acked
//   o_fb_req, o_fb_addr,
//   o_fb_data, i_fb_ack          framebuffer write handshake
//   o_overflow                   sticky pixel-drop flag
//   o_clip_count                 saturating clipped-pixel count
module raster_fb_write_scheduler
    import raster_fb_write_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int STALL_MARGIN = 5,
    parameter int FB_WIDTH     = FB_WIDTH_DEF,
    parameter int FB_HEIGHT    = FB_HEIGHT_DEF,
    parameter int ADDR_W       = 17
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_write_pixel,
    input  logic signed [15:0] i_x,
    input  logic signed [15:0] i_y,
    input  logic [7:0]         i_r,
    input  logic [7:0]         i_g,
    input  logic [7:0]         i_b,
    output logic               o_stall,
    input  logic               i_clear_req,
    input  logic [23:0]        i_clear_rgb,
    output logic               o_clear_busy,
    output logic               o_clear_done,
    output logic               o_fb_req,
    output logic [ADDR_W-1:0]  o_fb_addr,
    output logic [23:0]        o_fb_data,
    input  logic               i_fb_ack,
    output logic               o_overflow,
    output logic [15:0]        o_clip_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = ADDR_W + RGB_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

    // Clip and address generation
    logic              in_bounds, pix_push, pix_clip;
    logic [ADDR_W-1:0] pix_addr;

    assign in_bounds = pix_in_bounds(i_x, i_y, FB_WIDTH, FB_HEIGHT);
    assign pix_push  = i_write_pixel & in_bounds;
    assign pix_clip  = i_write_pixel & ~in_bounds;
    assign pix_addr  = ADDR_W'(fb_addr(i_x, i_y, FB_WIDTH));

    // FIFO
    logic [DW-1:0] fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, pop, push_acc;

    raster_fb_write_scheduler_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (pix_push),
        .i_wdata ({pix_addr, rgb_pack(i_r, i_g, i_b)}),
        .i_pop   (pop),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign push_acc = pix_push & (~fifo_full | pop);

    // Scheduler state
    fb_state_e         state_q;
    logic              req_q, busy_q, done_q, stall_q, ovf_q;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       data_q, clr_rgb_q;
    logic [CW-1:0]     drain_cnt_q;
    logic [15:0]       clip_cnt_q;

    logic          accept, fire, can_load, clear_last, busy_d, stall_d;
    logic [CW-1:0] count_d, free_d;

    assign accept     = i_clear_req & ~busy_q;
    assign fire       = req_q & i_fb_ack;
    // The output register may take a new write when empty or being acked now.
    assign can_load   = ~req_q | i_fb_ack;
    assign clear_last = (state_q == ST_CLEAR) & fire & (addr_q == LAST_ADDR);

    // A clear accept freezes pixel issue for that cycle so the drain count
    // latched from the FIFO occupancy stays exact.
    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            ST_PIXEL: pop = ~accept & can_load & ~fifo_empty;
            ST_DRAIN: pop = can_load & (drain_cnt_q != '0);
            default:  pop = 1'b0;
        endcase
    end

    // Stall is registered from next-cycle occupancy and busy state.
    assign busy_d  = accept | (busy_q & ~clear_last);
    assign count_d = fifo_count + CW'(push_acc) - CW'(pop);
    assign free_d  = CW'(FIFO_DEPTH) - count_d;
    assign stall_d = (free_d <= CW'(STALL_MARGIN)) | busy_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
            drain_cnt_q <= '0;
            clr_rgb_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
            done_q  <= clear_last;
            if (fire) req_q <= 1'b0;
            if (pop) begin
                req_q  <= 1'b1;
                addr_q <= fifo_rdata[DW-1:RGB_W];
                data_q <= fifo_rdata[RGB_W-1:0];
            end
            if (accept) clr_rgb_q <= i_clear_rgb;

            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= fifo_count;
                    end else if (!fifo_empty) begin
                        state_q <= ST_PIXEL;
                    end
                end
                ST_PIXEL: begin
                    // Any outstanding write simply completes in DRAIN; only
                    // entries still queued at accept need to be counted.
                    if (accept) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= fifo_count;
                    end else if (fifo_empty && can_load) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (pop) begin
                        drain_cnt_q <= drain_cnt_q - CW'(1);
                    end else if (drain_cnt_q == '0 && can_load) begin
                        state_q <= ST_CLEAR;
                        req_q   <= 1'b1;
                        addr_q  <= '0;
                        data_q  <= clr_rgb_q;
                    end
                end
                ST_CLEAR: begin
                    // addr_q doubles as the clear address counter.
                    if (fire) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= fifo_empty ? ST_IDLE : ST_PIXEL;
                        end else begin
                            req_q  <= 1'b1;
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clip_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (pix_clip && clip_cnt_q != 16'hFFFF) clip_cnt_q <= clip_cnt_q + 16'd1;
            if (pix_push && fifo_full && !pop)      ovf_q      <= 1'b1;
        end
    end

    assign o_stall      = stall_q;
    assign o_clear_busy = busy_q;
    assign o_clear_done = done_q;
    assign o_fb_req     = req_q;
    assign o_fb_addr    = addr_q;
    assign o_fb_data    = data_q;
    assign o_overflow   = ovf_q;
    assign o_clip_count = clip_cnt_q;

endmodule

// File: tb/tb_raster_fb_write_scheduler.sv
// Directed bench for raster_fb_write_scheduler with hand-computed expectations.
module tb_raster_fb_write_scheduler;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_write_pixel;
    logic signed [15:0] i_x, i_y;
    logic [7:0]         i_r, i_g, i_b;
    logic               o_stall;
    logic               i_clear_req;
    logic [23:0]        i_clear_rgb;
    logic               o_clear_busy, o_clear_done;
    logic               o_fb_req;
    logic [16:0]        o_fb_addr;
    logic [23:0]        o_fb_data;
    logic               i_fb_ack;
    logic               o_overflow;
    logic [15:0]        o_clip_count;

    always #5 clk = ~clk;

    raster_fb_write_scheduler dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_write_pixel (i_write_pixel),
        .i_x           (i_x),
        .i_y           (i_y),
        .i_r           (i_r),
        .i_g           (i_g),
        .i_b           (i_b),
        .o_stall       (o_stall),
        .i_clear_req   (i_clear_req),
        .i_clear_rgb   (i_clear_rgb),
        .o_clear_busy  (o_clear_busy),
        .o_clear_done  (o_clear_done),
        .o_fb_req      (o_fb_req),
        .o_fb_addr     (o_fb_addr),
        .o_fb_data     (o_fb_data),
        .i_fb_ack      (i_fb_ack),
        .o_overflow    (o_overflow),
        .o_clip_count  (o_clip_count)
    );

    int total = 0;
    int passed = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [16:0] wa[$];
    logic [23:0] wd[$];

    // Record every accepted framebuffer write and every done pulse.
    always @(posedge clk) begin
        if (rst_n) begin
            if (o_fb_req && i_fb_ack) begin
                wa.push_back(o_fb_addr);
                wd.push_back(o_fb_data);
            end
            if (o_clear_done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic px(input logic v, input int x, input int y, input logic [23:0] rgb);
        i_write_pixel = v;
        i_x = 16'(x);
        i_y = 16'(y);
        {i_r, i_g, i_b} = rgb;
    endtask

    initial begin
        rst_n = 1'b0;
        i_fb_ack = 1'b0;
        i_clear_req = 1'b0;
        i_clear_rgb = '0;
        px(1'b0, 0, 0, 24'h0);
        repeat (3) tick();

        // Reset state
        check("rst_req",   32'(o_fb_req), 32'd0);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_busy",  32'(o_clear_busy), 32'd0);
        check("rst_done",  32'(o_clear_done), 32'd0);
        check("rst_ovf",   32'(o_overflow), 32'd0);
        check("rst_clip",  32'(o_clip_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single pixel latency, ack tied high
        i_fb_ack = 1'b1;
        px(1'b1, 10, 2, 24'h112233);
        tick();
        px(1'b0, 0, 0, 24'h0);
        check("t1_req_e0", 32'(o_fb_req), 32'd0);
        tick();
        check("t1_req_e1", 32'(o_fb_req), 32'd0);
        tick();
        check("t1_req_e2",  32'(o_fb_req), 32'd1);
        check("t1_addr_e2", 32'(o_fb_addr), 32'd650);
        check("t1_data_e2", 32'(o_fb_data), 32'h112233);
        tick();
        check("t1_req_e3", 32'(o_fb_req), 32'd0);
        check("t1_nwr", 32'(wa.size()), 32'd1);

        // 2: clipping on every edge, plus the far corner in bounds
        wa.delete(); wd.delete();
        px(1'b1, -1, 0, 24'h445566);   tick();
        px(1'b1, 320, 0, 24'h445566);  tick();
        px(1'b1, 0, 240, 24'h445566);  tick();
        px(1'b1, 0, -1, 24'h445566);   tick();
        px(1'b1, 319, 239, 24'h445566); tick();
        px(1'b0, 0, 0, 24'h0);
        repeat (5) tick();
        check("t2_nwr",  32'(wa.size()), 32'd1);
        check("t2_addr", 32'(wa[0]), 32'd76799);
        check("t2_data", 32'(wd[0]), 32'h445566);
        check("t2_clip", 32'(o_clip_count), 32'd4);

        // 3: ack held low. One write sits in the output register, so the
        // FIFO (8 deep) fills on the 9th push and the 10th is dropped.
        wa.delete(); wd.delete();
        i_fb_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            px(1'b1, i, 5, {3{8'(i)}});
            tick();
            if (i == 2) check("t3_stall_lo", 32'(o_stall), 32'd0);
            if (i == 3) check("t3_stall_hi", 32'(o_stall), 32'd1);
            if (i == 8) check("t3_ovf_lo", 32'(o_overflow), 32'd0);
        end
        px(1'b0, 0, 0, 24'h0);
        check("t3_ovf_hi", 32'(o_overflow), 32'd1);
        check("t3_req_held", 32'(o_fb_req), 32'd1);
        check("t3_addr_held", 32'(o_fb_addr), 32'd1600);
        i_fb_ack = 1'b1;
        repeat (15) tick();
        check("t3_nwr", 32'(wa.size()), 32'd9);
        for (int j = 0; j < 9 && j < wa.size(); j++) begin
            check($sformatf("t3_addr%0d", j), 32'(wa[j]), 32'(1600 + j));
            check($sformatf("t3_data%0d", j), 32'(wd[j]), 32'({3{8'(j)}}));
        end
        check("t3_stall_end", 32'(o_stall), 32'd0);
        check("t3_ovf_sticky", 32'(o_overflow), 32'd1);

        // 4+5: three queued pixels, clear with a pixel in the same cycle,
        // and a second clear request mid-clear that must be ignored.
        wa.delete(); wd.delete();
        done_cnt = 0;
        i_fb_ack = 1'b0;
        px(1'b1, 1, 1, 24'hA1A1A1); tick();
        px(1'b1, 2, 1, 24'hB2B2B2); tick();
        px(1'b1, 3, 1, 24'hC3C3C3); tick();
        px(1'b1, 4, 1, 24'hD4D4D4);
        i_clear_req = 1'b1;
        i_clear_rgb = 24'h000000;
        tick();
        px(1'b0, 0, 0, 24'h0);
        i_clear_req = 1'b0;
        check("t4_busy", 32'(o_clear_busy), 32'd1);
        check("t4_stall", 32'(o_stall), 32'd1);
        i_fb_ack = 1'b1;
        begin
            int n;
            n = 0;
            while (done_cnt == 0 && n < 80000) begin
                if (n == 1000) begin
                    i_clear_req = 1'b1;
                    i_clear_rgb = 24'hFFFFFF;
                end else begin
                    i_clear_req = 1'b0;
                end
                tick();
                n++;
            end
            i_clear_req = 1'b0;
            check("t4_done_in_time", 32'(n < 80000), 32'd1);
        end
        repeat (10) tick();
        check("t5_done_once", 32'(done_cnt), 32'd1);
        check("t4_busy_end", 32'(o_clear_busy), 32'd0);
        check("t4_stall_end", 32'(o_stall), 32'd0);
        check("t4_nwr", 32'(wa.size()), 32'd76804);
        if (wa.size() == 76804) begin
            int errs;
            errs = 0;
            check("t4_p0", 32'(wa[0]), 32'd321);
            check("t4_p1", 32'(wa[1]), 32'd322);
            check("t4_p2", 32'(wa[2]), 32'd323);
            check("t4_p2_data", 32'(wd[2]), 32'hC3C3C3);
            for (int k = 0; k < 76800; k++)
                if (wa[3 + k] !== 17'(k) || wd[3 + k] !== 24'h000000) errs++;
            check("t4_clear_seq_errs", 32'(errs), 32'd0);
            check("t4_after_addr", 32'(wa[76803]), 32'd324);
            check("t4_after_data", 32'(wd[76803]), 32'hD4D4D4);
        end

        // 6: asynchronous reset in the middle of a clear
        done_cnt = 0;
        i_clear_req = 1'b1;
        i_clear_rgb = 24'h123456;
        tick();
        i_clear_req = 1'b0;
        repeat (100) tick();
        check("t6_busy_mid", 32'(o_clear_busy), 32'd1);
        check("t6_req_mid",  32'(o_fb_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_req",  32'(o_fb_req), 32'd0);
        check("t6_rst_busy", 32'(o_clear_busy), 32'd0);
        check("t6_rst_stall", 32'(o_stall), 32'd0);
        check("t6_rst_addr", 32'(o_fb_addr), 32'd0);
        check("t6_rst_ovf",  32'(o_overflow), 32'd0);
        check("t6_rst_clip", 32'(o_clip_count), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_req_idle", 32'(o_fb_req), 32'd0);
        px(1'b1, 20, 3, 24'h778899);
        tick();
        px(1'b0, 0, 0, 24'h0);
        check("t6_req_e0", 32'(o_fb_req), 32'd0);
        tick();
        check("t6_req_e1", 32'(o_fb_req), 32'd0);
        tick();
        check("t6_req_e2",  32'(o_fb_req), 32'd1);
        check("t6_addr_e2", 32'(o_fb_addr), 32'd980);
        check("t6_data_e2", 32'(o_fb_data), 32'h778899);
        tick();
        check("t6_req_e3", 32'(o_fb_req), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
